// File: rtl/cdp_pkg.sv
// Shared constants, FSM state type and path-length helpers for the
// selection-stage fitness front-end (comp_distance_pop / pop_sorter).
package cdp_pkg;

    localparam int N_IND  = 50;
    localparam int IND_W  = 150;
    localparam int N_WP   = 15;
    localparam int DIST_W = 12;
    localparam int IDX_W  = 6;
    localparam int WP_W   = 10;
    localparam int CRD_W  = 5;
    localparam int N_SEG  = N_WP - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [CRD_W-1:0] abs_diff(input logic [CRD_W-1:0] a,
                                                  input logic [CRD_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Waypoint is {x, y}; one segment is the Manhattan step between two waypoints.
    function automatic logic [CRD_W:0] seg_len(input logic [WP_W-1:0] p,
                                               input logic [WP_W-1:0] q);
        return {1'b0, abs_diff(p[WP_W-1:CRD_W], q[WP_W-1:CRD_W])}
             + {1'b0, abs_diff(p[CRD_W-1:0], q[CRD_W-1:0])};
    endfunction

    function automatic logic [DIST_W-1:0] path_len(input logic [IND_W-1:0] ind);
        logic [DIST_W-1:0] acc;
        acc = '0;
        for (int w = 0; w < N_SEG; w++) begin
            acc = acc + DIST_W'(seg_len(ind[WP_W*(w+1) +: WP_W], ind[WP_W*w +: WP_W]));
        end
        return acc;
    endfunction

endpackage

// File: rtl/path_len_unit.sv
// Combinational 14-segment Manhattan path length of one individual,
// built as a balanced adder tree over the segment lengths.
module path_len_unit
    import cdp_pkg::*;
(
    input  logic [IND_W-1:0]  ind_i,
    output logic [DIST_W-1:0] len_o
);

    logic [5:0] seg [N_SEG];
    logic [6:0] lv1 [7];
    logic [7:0] lv2 [4];
    logic [8:0] lv3 [2];
    logic [9:0] lv4;

    for (genvar w = 0; w < N_SEG; w++) begin : g_seg
        assign seg[w] = seg_len(ind_i[WP_W*(w+1) +: WP_W], ind_i[WP_W*w +: WP_W]);
    end

    for (genvar i = 0; i < 7; i++) begin : g_lv1
        assign lv1[i] = {1'b0, seg[2*i]} + {1'b0, seg[2*i+1]};
    end

    // Seven level-1 sums: the odd one out is carried straight up a level.
    for (genvar i = 0; i < 3; i++) begin : g_lv2
        assign lv2[i] = {1'b0, lv1[2*i]} + {1'b0, lv1[2*i+1]};
    end
    assign lv2[3] = {1'b0, lv1[6]};

    assign lv3[0] = {1'b0, lv2[0]} + {1'b0, lv2[1]};
    assign lv3[1] = {1'b0, lv2[2]} + {1'b0, lv2[3]};
    assign lv4    = {1'b0, lv3[0]} + {1'b0, lv3[1]};

    assign len_o = {{(DIST_W-10){1'b0}}, lv4};

endmodule

// File: rtl/pop_sorter.sv
// Stable ascending rank of 50 distances by odd-even transposition,
// one compare-exchange pass per cycle over (key, index) pairs.
module pop_sorter
    import cdp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N_IND*DIST_W-1:0]  in,
    output logic [N_IND*IDX_W-1:0]   sorted,
    output logic                     done
);

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              done_q;
    logic [DIST_W-1:0] key_q [N_IND];
    logic [DIST_W-1:0] key_d [N_IND];
    logic [IDX_W-1:0]  idx_q [N_IND];
    logic [IDX_W-1:0]  idx_d [N_IND];
    logic              accept;

    assign accept = (state_q == IDLE) && start;

    // Pass parity follows the counter; swapping only on strictly greater keeps ties in index order.
    always_comb begin
        key_d = key_q;
        idx_d = idx_q;
        for (int i = 0; i < N_IND - 1; i++) begin
            if ((i[0] == cnt_q[0]) && (key_q[i] > key_q[i+1])) begin
                key_d[i]   = key_q[i+1];
                key_d[i+1] = key_q[i];
                idx_d[i]   = idx_q[i+1];
                idx_d[i+1] = idx_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_IND; k++) begin
                key_q[k] <= in[k*DIST_W +: DIST_W];
            end
        end else if (state_q == RUN) begin
            key_q <= key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_IND; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                        for (int k = 0; k < N_IND; k++) begin
                            idx_q[k] <= IDX_W'(k);
                        end
                    end
                end
                RUN: begin
                    idx_q <= idx_d;
                    if (cnt_q == IDX_W'(N_IND - 1)) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    if (done_q && !start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N_IND; r++) begin : g_out
        assign sorted[r*IDX_W +: IDX_W] = idx_q[r];
    end

    assign done = done_q;

endmodule

// File: rtl/comp_distance_pop.sv
// Computes the path length of each of the 50 individuals, one per cycle,
// from a population snapshot taken when the run is accepted.
module comp_distance_pop
    import cdp_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_IND*IND_W-1:0]    pop,
    output logic [N_IND*DIST_W-1:0]   distances,
    output logic                      done
);

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              done_q;
    logic [IND_W-1:0]  pop_q  [N_IND];
    logic [DIST_W-1:0] dist_q [N_IND];
    logic [IND_W-1:0]  cur_ind;
    logic [DIST_W-1:0] cur_len;
    logic              accept;

    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_IND; k++) begin
                pop_q[k] <= pop[k*IND_W +: IND_W];
            end
        end
    end

    assign cur_ind = pop_q[cnt_q];

    path_len_unit u_len (
        .ind_i (cur_ind),
        .len_o (cur_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_IND; k++) begin
                dist_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    dist_q[cnt_q] <= cur_len;
                    if (cnt_q == IDX_W'(N_IND - 1)) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    // done is raised on the first DONE cycle and held until start is released.
                    done_q <= 1'b1;
                    if (done_q && !start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_IND; k++) begin : g_out
        assign distances[k*DIST_W +: DIST_W] = dist_q[k];
    end

    assign done = done_q;

endmodule

// File: tb/tb_comp_distance_pop.sv
// Directed bench for comp_distance_pop and pop_sorter: reset, latency,
// handshake, input capture, mid-run reset and sort stability.
module tb_comp_distance_pop;

    logic         clk;
    logic         rst_n;
    logic         start_c;
    logic         start_s;
    logic [7499:0] pop;
    logic [599:0] distances;
    logic         done_c;
    logic [599:0] sin;
    logic [299:0] sorted;
    logic         done_s;

    int ntests;
    int nfail;
    int lat_c;
    int lat_s;

    logic [7499:0] pop7, popA, popB;
    logic [599:0]  exp_d7, exp_dA, sin7, sin_rev, sin_mod5;
    logic [299:0]  exp_id, exp_s7, exp_rev, exp_mod5;

    comp_distance_pop dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_c),
        .pop       (pop),
        .distances (distances),
        .done      (done_c)
    );

    pop_sorter srt (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s),
        .in     (sin),
        .sorted (sorted),
        .done   (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_v(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_wp(inout logic [7499:0] v, input int k, input int w, input int x, input int y);
        v[150*k + 10*w +: 10] = {5'(x), 5'(y)};
    endtask

    // Starts both blocks together; latency counts edges after the accepting edge.
    task automatic run_both(input bit mutate);
        start_c = 1'b1;
        start_s = 1'b1;
        tick;
        lat_c = -1;
        lat_s = -1;
        for (int n = 1; n <= 200 && (lat_c < 0 || lat_s < 0); n++) begin
            if (mutate && n == 5) begin
                pop = popB;
                sin = '0;
            end
            tick;
            if (done_c && lat_c < 0) lat_c = n;
            if (done_s && lat_s < 0) lat_s = n;
        end
    endtask

    task automatic drop_start(input string tag);
        start_c = 1'b0;
        start_s = 1'b0;
        tick;
        check_i({tag, "_done_c_fall"}, int'(done_c), 0);
        check_i({tag, "_done_s_fall"}, int'(done_s), 0);
        tick;
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;

        pop7 = '0;
        popA = '0;
        popB = '0;
        for (int w = 0; w < 15; w++) begin
            set_wp(pop7, 7, w, (w % 2) ? 31 : 0, (w % 2) ? 31 : 0);
            set_wp(popA, 3, w, w % 2, 0);
            set_wp(popA, 20, w, w, w);
            set_wp(popA, 40, w, 31 - w, 20 - w);
            for (int k = 0; k < 50; k++) begin
                set_wp(popB, k, w, (w % 2) ? 31 : 0, (w % 2) ? 31 : 0);
            end
        end
        exp_d7 = '0;
        exp_d7[12*7 +: 12] = 12'd868;
        exp_dA = '0;
        exp_dA[12*3 +: 12]  = 12'd14;
        exp_dA[12*20 +: 12] = 12'd28;
        exp_dA[12*40 +: 12] = 12'd28;
        sin7 = exp_d7;

        for (int k = 0; k < 50; k++) begin
            sin_rev[12*k +: 12]  = 12'(49 - k);
            sin_mod5[12*k +: 12] = 12'(k % 5);
            exp_id[6*k +: 6]     = 6'(k);
            exp_rev[6*k +: 6]    = 6'(49 - k);
            exp_mod5[6*k +: 6]   = 6'(5 * (k % 10) + k / 10);
        end
        for (int r = 0; r < 7; r++) exp_s7[6*r +: 6] = 6'(r);
        for (int r = 7; r < 49; r++) exp_s7[6*r +: 6] = 6'(r + 1);
        exp_s7[6*49 +: 6] = 6'd7;

        rst_n   = 1'b0;
        start_c = 1'b0;
        start_s = 1'b0;
        pop     = '0;
        sin     = '0;
        tick;
        tick;
        check_i("rst_done_c", int'(done_c), 0);
        check_i("rst_done_s", int'(done_s), 0);
        check_v("rst_distances", distances, '0);
        check_v("rst_sorted", {300'b0, sorted}, '0);
        rst_n = 1'b1;
        tick;

        // All-zero population: identity ranking, then hold start past done.
        run_both(1'b0);
        check_i("zero_lat_c", lat_c, 51);
        check_i("zero_lat_s", lat_s, 51);
        check_v("zero_distances", distances, '0);
        check_v("zero_sorted", {300'b0, sorted}, {300'b0, exp_id});
        repeat (10) tick;
        check_i("hold_done_c", int'(done_c), 1);
        check_i("hold_done_s", int'(done_s), 1);
        check_v("hold_distances", distances, '0);
        check_v("hold_sorted", {300'b0, sorted}, {300'b0, exp_id});
        drop_start("zero");

        // Maximum-length individual 7.
        pop = pop7;
        sin = sin7;
        run_both(1'b0);
        check_i("max_lat_c", lat_c, 51);
        check_i("max_lat_s", lat_s, 51);
        check_v("max_distances", distances, exp_d7);
        check_v("max_sorted", {300'b0, sorted}, {300'b0, exp_s7});
        drop_start("max");

        // Inputs change mid-run; only the accepted snapshot counts.
        pop = popA;
        sin = sin_rev;
        run_both(1'b1);
        check_i("cap_lat_c", lat_c, 51);
        check_v("cap_distances", distances, exp_dA);
        check_v("cap_sorted_rev", {300'b0, sorted}, {300'b0, exp_rev});
        drop_start("cap");

        sin = sin_mod5;
        run_both(1'b0);
        check_i("mod5_lat_s", lat_s, 51);
        check_v("mod5_sorted", {300'b0, sorted}, {300'b0, exp_mod5});
        check_v("mod5_distances", distances, {600{1'b0}} | {50{12'd868}});
        drop_start("mod5");

        // Reset asserted in RUN cycle 20.
        pop = pop7;
        sin = sin_rev;
        start_c = 1'b1;
        start_s = 1'b1;
        tick;
        repeat (19) tick;
        rst_n = 1'b0;
        tick;
        check_i("mrst_done_c", int'(done_c), 0);
        check_i("mrst_done_s", int'(done_s), 0);
        check_v("mrst_distances", distances, '0);
        check_v("mrst_sorted", {300'b0, sorted}, '0);
        start_c = 1'b0;
        start_s = 1'b0;
        rst_n   = 1'b1;
        tick;

        run_both(1'b0);
        check_i("rerun_lat_c", lat_c, 51);
        check_i("rerun_lat_s", lat_s, 51);
        check_v("rerun_distances", distances, exp_d7);
        check_v("rerun_sorted", {300'b0, sorted}, {300'b0, exp_rev});
        drop_start("rerun");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
